if_stage: RTL and testbench

Instruction-fetch stage of the in-order RISC-V pipeline; sits directly upstream of the decode stage. Issues word fetches on the instruction bus and tracks their PCs. Buffers returned instructions in a small prefetch FIFO. Presents the FIFO head to decode as `pc_id`/`instr_payload`/`instr_value`/`instr_fetch_error`. Redirects from branch/jump/trap resolution flush the FIFO and discard in-flight responses.

---
 rtl/if_stage.sv | 214 +++++++++++++++++++++
 tb/tb_if_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues word fetches under a credit limit, pairs responses with
// their PCs, buffers them in a prefetch FIFO for decode, and flushes on redirect.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall_F,
  input  logic        ready_id,
  output logic [31:0] pc_id,
  output logic [31:0] instr_payload,
  output logic        instr_value,
  output logic        instr_fetch_error
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  // Control state
  logic [0:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_hold_q, req_hold_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_q, drop_d;

  // PC queue: address of every granted request, popped in order by responses
  logic [31:0] pcq_mem_q [FIFO_DEPTH];
  logic [31:0] pcq_mem_d [FIFO_DEPTH];
  ptr_t        pcq_wptr_q, pcq_wptr_d;
  ptr_t        pcq_rptr_q, pcq_rptr_d;

  // Prefetch FIFO presented to decode
  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_pc_d   [FIFO_DEPTH];
  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [31:0] fifo_data_d [FIFO_DEPTH];
  logic        fifo_err_q  [FIFO_DEPTH];
  logic        fifo_err_d  [FIFO_DEPTH];
  ptr_t        fifo_wptr_q, fifo_wptr_d;
  ptr_t        fifo_rptr_q, fifo_rptr_d;
  cnt_t        fifo_count_q, fifo_count_d;

  logic [CW:0] in_use;
  logic        credit_ok;
  logic        grant;
  logic        pop;
  logic        keep;
  logic [31:0] redir_tgt;
  logic [31:0] rsp_pc;
  logic        unused_redirect_lsbs;

  // Requests in flight plus buffered entries may never exceed the FIFO capacity.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
  assign credit_ok = in_use < DEPTH_W;

  assign instr_req  = (state_q == ST_RUN) && (req_hold_q || credit_ok);
  assign instr_addr = fetch_pc_q;

  assign grant     = instr_req && instr_gnt;
  assign pop       = instr_value && ready_id && !stall_F;
  assign keep      = instr_rvalid && (drop_q == '0) && !redirect_en;
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign rsp_pc    = pcq_mem_q[pcq_rptr_q];

  // Word alignment is forced, so the low redirect bits carry no information.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign instr_value       = fifo_count_q != '0;
  assign pc_id             = fifo_pc_q[fifo_rptr_q];
  assign instr_payload     = fifo_data_q[fifo_rptr_q];
  assign instr_fetch_error = instr_value && fifo_err_q[fifo_rptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d      = ST_RUN;
    req_hold_d   = instr_req && !instr_gnt;
    fetch_pc_d   = fetch_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;

    if (grant) begin
      redir_pend_d = 1'b0;
      if (redirect_en) begin
        fetch_pc_d = redir_tgt;
      end else if (redir_pend_q) begin
        fetch_pc_d = redir_pc_q;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end else if (redirect_en) begin
      // A request already on the bus keeps its address; the new target waits for its grant.
      if (instr_req) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = redir_tgt;
      end else begin
        fetch_pc_d = redir_tgt;
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(instr_rvalid);

    drop_d = drop_q;
    if (instr_rvalid && (drop_q != '0)) begin
      drop_d = drop_d - cnt_t'(1);
    end
    if (grant && redir_pend_q) begin
      drop_d = drop_d + cnt_t'(1);
    end
    if (redirect_en) begin
      drop_d = outstanding_d;
    end
  end

  always_comb begin
    pcq_mem_d  = pcq_mem_q;
    pcq_wptr_d = pcq_wptr_q;
    pcq_rptr_d = pcq_rptr_q;

    if (grant) begin
      pcq_mem_d[pcq_wptr_q] = fetch_pc_q;
      pcq_wptr_d            = pcq_wptr_q + ptr_t'(1);
    end
    if (instr_rvalid) begin
      pcq_rptr_d = pcq_rptr_q + ptr_t'(1);
    end
  end

  always_comb begin
    fifo_pc_d    = fifo_pc_q;
    fifo_data_d  = fifo_data_q;
    fifo_err_d   = fifo_err_q;
    fifo_wptr_d  = fifo_wptr_q;
    fifo_rptr_d  = fifo_rptr_q;
    fifo_count_d = fifo_count_q;

    if (redirect_en) begin
      // Flush leaves the slot contents alone; only occupancy is cleared.
      fifo_count_d = '0;
      fifo_wptr_d  = fifo_rptr_q;
    end else begin
      if (pop) begin
        fifo_rptr_d = fifo_rptr_q + ptr_t'(1);
      end
      if (keep) begin
        fifo_pc_d[fifo_wptr_q]   = rsp_pc;
        fifo_data_d[fifo_wptr_q] = instr_rdata;
        fifo_err_d[fifo_wptr_q]  = instr_err;
        fifo_wptr_d              = fifo_wptr_q + ptr_t'(1);
      end
      fifo_count_d = fifo_count_q + cnt_t'(keep) - cnt_t'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the combinational blocks above use blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= BOOT_ADDR;
      req_hold_q    <= 1'b0;
      redir_pend_q  <= 1'b0;
      redir_pc_q    <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      // NOTE: the storage arrays are reset because the head slot is visible on pc_id/instr_payload.
      pcq_mem_q     <= '{default: '0};
      pcq_wptr_q    <= '0;
      pcq_rptr_q    <= '0;
      fifo_pc_q     <= '{default: '0};
      fifo_data_q   <= '{default: '0};
      fifo_err_q    <= '{default: 1'b0};
      fifo_wptr_q   <= '0;
      fifo_rptr_q   <= '0;
      fifo_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_hold_q    <= req_hold_d;
      redir_pend_q  <= redir_pend_d;
      redir_pc_q    <= redir_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      pcq_mem_q     <= pcq_mem_d;
      pcq_wptr_q    <= pcq_wptr_d;
      pcq_rptr_q    <= pcq_rptr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_data_q   <= fifo_data_d;
      fifo_err_q    <= fifo_err_d;
      fifo_wptr_q   <= fifo_wptr_d;
      fifo_rptr_q   <= fifo_rptr_d;
      fifo_count_q  <= fifo_count_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a queue-based model of the fetch rules checked every cycle, a simple
// in-order bus responder, and directed scenarios with hand-computed expectations.
module tb_if_stage;

  localparam logic [31:0] BOOT  = 32'h8000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = '0;
  logic        instr_err = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_F = 1'b0;
  logic        ready_id = 1'b0;
  logic [31:0] pc_id;
  logic [31:0] instr_payload;
  logic        instr_value;
  logic        instr_fetch_error;

  logic gnt_en = 1'b0;
  logic rsp_en = 1'b0;

  assign instr_gnt = instr_req && gnt_en;

  if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall_F(stall_F), .ready_id(ready_id),
    .pc_id(pc_id), .instr_payload(instr_payload),
    .instr_value(instr_value), .instr_fetch_error(instr_fetch_error)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image seen by the bus responder
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'h8000_0000) + 32'h13;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a == 32'h0000_0040;
  endfunction

  // Behavioural model: in-flight requests and buffered entries as queues
  typedef struct {
    logic [31:0] pc;
    bit          drop;
  } infl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } ent_t;

  infl_t       infl_q[$];
  ent_t        fifo_m[$];
  logic [31:0] bus_q[$];
  bit          m_run = 1'b0;
  bit          m_hold = 1'b0;
  bit          m_rp = 1'b0;
  logic [31:0] m_fetch = BOOT;
  logic [31:0] m_rpc = '0;
  int          grant_cnt = 0;

  function automatic bit model_req();
    return m_run && (m_hold || (infl_q.size() + fifo_m.size() < DEPTH));
  endfunction

  // Per cycle: compare at negedge+1, drive responses at +2, advance model/bus at +4.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      check("instr_req", instr_req, model_req());
      check("instr_addr", instr_addr, m_fetch);
      check("instr_value", instr_value, fifo_m.size() != 0);
      if (fifo_m.size() != 0) begin
        check("pc_id", pc_id, fifo_m[0].pc);
        check("instr_payload", instr_payload, fifo_m[0].data);
        check("instr_fetch_error", instr_fetch_error, fifo_m[0].err);
      end else begin
        check("fetch_error_idle", instr_fetch_error, 1'b0);
      end
    end

    #1;
    if (reset_n && rsp_en && bus_q.size() > 0) begin
      instr_rvalid = 1'b1;
      instr_rdata  = mem_data(bus_q[0]);
      instr_err    = mem_err(bus_q[0]);
    end else begin
      instr_rvalid = 1'b0;
      instr_rdata  = '0;
      instr_err    = 1'b0;
    end

    #2;
    if (!reset_n) begin
      infl_q.delete();
      fifo_m.delete();
      bus_q.delete();
      m_run = 1'b0; m_hold = 1'b0; m_rp = 1'b0;
      m_fetch = BOOT; m_rpc = '0;
      grant_cnt = 0;
    end else begin
      bit          req;
      bit          grant;
      bit          keep;
      logic [31:0] kpc;
      logic [31:0] tgt;
      infl_t       f;
      ent_t        e;

      if (instr_rvalid) void'(bus_q.pop_front());
      if (instr_req && instr_gnt) begin
        bus_q.push_back(instr_addr);
        grant_cnt++;
      end

      req   = model_req();
      grant = req && gnt_en;
      tgt   = {redirect_pc[31:2], 2'b00};
      keep  = 1'b0;
      kpc   = '0;

      if (instr_rvalid) begin
        check("rsp_has_request", 32'(infl_q.size() != 0), 1);
        if (infl_q.size() != 0) begin
          f    = infl_q.pop_front();
          keep = !f.drop && !redirect_en;
          kpc  = f.pc;
        end
      end

      if (grant) begin
        f.pc   = m_fetch;
        f.drop = m_rp || redirect_en;
        infl_q.push_back(f);
        m_fetch = redirect_en ? tgt : (m_rp ? m_rpc : m_fetch + 32'd4);
        m_rp    = 1'b0;
      end else if (redirect_en) begin
        if (req) begin
          m_rp  = 1'b1;
          m_rpc = tgt;
        end else begin
          m_fetch = tgt;
        end
      end
      m_hold = req && !gnt_en;

      if (redirect_en) begin
        foreach (infl_q[k]) infl_q[k].drop = 1'b1;
        fifo_m.delete();
      end else begin
        if (fifo_m.size() != 0 && ready_id && !stall_F) void'(fifo_m.pop_front());
        if (keep) begin
          e.pc   = kpc;
          e.data = mem_data(kpc);
          e.err  = mem_err(kpc);
          fifo_m.push_back(e);
        end
      end
      m_run = 1'b1;
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  // Hold reset two cycles, check reset values, release at a negedge.
  task automatic do_reset();
    reset_n = 1'b0;
    redirect_en = 1'b0;
    nxt();
    nxt();
    check("rst_req", instr_req, 1'b0);
    check("rst_addr", instr_addr, BOOT);
    check("rst_value", instr_value, 1'b0);
    check("rst_err", instr_fetch_error, 1'b0);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_payload", instr_payload, 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    // Boot fetch and back-pressure
    gnt_en = 1'b1; rsp_en = 1'b1; ready_id = 1'b0; stall_F = 1'b0;
    do_reset();
    check("boot_no_req", instr_req, 1'b0);
    nxt();
    check("boot_req", instr_req, 1'b1);
    check("boot_addr", instr_addr, 32'h8000_0000);
    nxt();
    check("boot_addr2", instr_addr, 32'h8000_0004);
    nxt();
    check("boot_value", instr_value, 1'b1);
    check("boot_pc_id", pc_id, 32'h8000_0000);
    check("boot_payload", instr_payload, 32'h0000_0013);
    check("full_req", instr_req, 1'b0);
    repeat (4) nxt();
    check("bp_grants", grant_cnt, 2);
    check("bp_req", instr_req, 1'b0);
    check("bp_head", pc_id, 32'h8000_0000);
    ready_id = 1'b1;
    nxt();
    check("bp_head2", pc_id, 32'h8000_0004);
    check("bp_resume_req", instr_req, 1'b1);
    check("bp_resume_addr", instr_addr, 32'h8000_0008);
    nxt();
    check("bp_drained", instr_value, 1'b0);
    repeat (6) nxt();

    // Redirect with two requests outstanding
    gnt_en = 1'b1; rsp_en = 1'b0; ready_id = 1'b1;
    do_reset();
    nxt();
    nxt();
    nxt();
    check("rd_credit_out", instr_req, 1'b0);
    redirect_en = 1'b1; redirect_pc = 32'h0000_0102;
    nxt();
    redirect_en = 1'b0; rsp_en = 1'b1;
    check("rd_addr", instr_addr, 32'h0000_0100);
    check("rd_req_low", instr_req, 1'b0);
    check("rd_value0", instr_value, 1'b0);
    nxt();
    check("rd_req", instr_req, 1'b1);
    check("rd_value1", instr_value, 1'b0);
    nxt();
    check("rd_value2", instr_value, 1'b0);
    check("rd_addr_next", instr_addr, 32'h0000_0104);
    nxt();
    check("rd_new_value", instr_value, 1'b1);
    check("rd_new_pc", pc_id, 32'h0000_0100);
    check("rd_new_payload", instr_payload, 32'h8000_0113);
    repeat (4) nxt();

    // Redirect while a request waits for grant, then an error response
    gnt_en = 1'b0; rsp_en = 1'b1; ready_id = 1'b0;
    do_reset();
    nxt();
    nxt();
    check("pend_req", instr_req, 1'b1);
    redirect_en = 1'b1; redirect_pc = 32'h0000_0040;
    nxt();
    redirect_en = 1'b0;
    check("pend_hold_req", instr_req, 1'b1);
    check("pend_hold_addr1", instr_addr, 32'h8000_0000);
    nxt();
    check("pend_hold_addr2", instr_addr, 32'h8000_0000);
    nxt();
    check("pend_hold_addr3", instr_addr, 32'h8000_0000);
    gnt_en = 1'b1;
    nxt();
    check("pend_new_addr", instr_addr, 32'h0000_0040);
    check("pend_value0", instr_value, 1'b0);
    nxt();
    check("err_next_addr", instr_addr, 32'h0000_0044);
    check("pend_dropped", instr_value, 1'b0);
    nxt();
    check("err_value", instr_value, 1'b1);
    check("err_flag", instr_fetch_error, 1'b1);
    check("err_pc", pc_id, 32'h0000_0040);
    ready_id = 1'b1;
    repeat (4) nxt();

    // Redirect to the top word: address wraps to zero
    gnt_en = 1'b1; rsp_en = 1'b1; ready_id = 1'b1;
    do_reset();
    nxt();
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nxt();
    redirect_en = 1'b0;
    check("wrap_addr_top", instr_addr, 32'hFFFF_FFFC);
    nxt();
    check("wrap_addr_zero", instr_addr, 32'h0000_0000);
    nxt();
    check("wrap_pc", pc_id, 32'hFFFF_FFFC);
    check("wrap_payload", instr_payload, 32'h8000_000F);

    // Table-driven sweep of handshake patterns with periodic redirects and a mid-run reset
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        do_reset();
      end
      gnt_en      = (i % 5) != 2;
      rsp_en      = (i % 7) < 5;
      ready_id    = (i % 4) != 1;
      stall_F     = (i % 11) == 6;
      redirect_en = ((i % 23) == 9) || ((i % 41) == 17);
      redirect_pc = ((i % 46) == 9) ? 32'hFFFF_FFF8
                                    : 32'h38 + 32'(i % 3) * 32'd4 + 32'(i % 4);
      nxt();
    end
    redirect_en = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1; ready_id = 1'b1; stall_F = 1'b0;
    repeat (8) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
